// File: rtl/arm_alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/shift ops plus an iterative shift-add multiplier,
// with a registered result, NZCV flags and a start/busy/done handshake.
module arm_alu_mc #(
   parameter int WIDTH  = 16,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic             cin,
   input  logic [WIDTH-1:0] rd_data,
   input  logic [WIDTH-1:0] rs_data,
   output logic             busy,
   output logic             done,
   output logic             wen,
   output logic [WIDTH-1:0] d_out,
   output logic [3:0]       flags
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MOV  = 3'b010;
   localparam logic [2:0] OP_LSR  = 3'b011;
   localparam logic [2:0] OP_DEC  = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_LSL  = 3'b110;
   localparam logic [2:0] OP_PASS = 3'b111;

   typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

   state_t                 state;
   logic [WIDTH-1:0]       add_a;
   logic [WIDTH-1:0]       add_b;
   logic                   add_ci;
   logic [WIDTH:0]         add_sum;
   logic [WIDTH-1:0]       sc_res;
   logic                   sc_c;
   logic                   sc_v;
   logic [2*WIDTH-1:0]     mcand;
   logic [2*WIDTH-1:0]     acc;
   logic [2*WIDTH-1:0]     acc_nxt;
   logic [WIDTH-1:0]       mplier;
   logic [CNT_W-1:0]       cnt;
   logic                   accept;
   logic                   accept_mul;

   // Two's-complement overflow: operands agree in sign, sum disagrees.
   function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] s);
      return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
   endfunction

   function automatic logic is_zero(input logic [WIDTH-1:0] v);
      return (v == '0);
   endfunction

   // Shared adder: sub is rd + ~rs + 1, mov is rs + cin, dec is rs + all-ones.
   always_comb begin
      add_a  = rd_data;
      add_b  = rs_data;
      add_ci = 1'b0;
      case (op)
         OP_SUB: begin
            add_b  = ~rs_data;
            add_ci = 1'b1;
         end
         OP_MOV: begin
            add_a  = rs_data;
            add_b  = '0;
            add_ci = cin;
         end
         OP_DEC: begin
            add_a = rs_data;
            add_b = '1;
         end
         default: ;
      endcase
      add_sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};
   end

   always_comb begin
      sc_res = add_sum[WIDTH-1:0];
      sc_c   = add_sum[WIDTH];
      sc_v   = add_ovf($signed(add_a), $signed(add_b), $signed(add_sum[WIDTH-1:0]));
      case (op)
         OP_LSR: begin
            sc_res = {1'b0, rs_data[WIDTH-1:1]};
            sc_c   = rs_data[0];
            sc_v   = 1'b0;
         end
         OP_LSL: begin
            sc_res = {rs_data[WIDTH-2:0], 1'b0};
            sc_c   = rs_data[WIDTH-1];
            sc_v   = 1'b0;
         end
         // mul only reaches here when the multiplier is disabled: plain pass of rd
         OP_MUL, OP_PASS: begin
            sc_res = rd_data;
            sc_c   = 1'b0;
            sc_v   = 1'b0;
         end
         default: ;
      endcase
   end

   assign accept     = (state == IDLE) && start;
   assign accept_mul = accept && (op == OP_MUL) && (MUL_EN != 0);
   assign acc_nxt    = mplier[0] ? (acc + mcand) : acc;
   assign wen        = done;

   // Multiplier operand shifters carry no reset; they are reloaded on every accepted mul.
   always_ff @(posedge clk) begin
      if (accept_mul) begin
         mcand  <= {{WIDTH{1'b0}}, rd_data};
         mplier <= rs_data;
      end else if (state == MUL) begin
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         d_out <= '0;
         flags <= 4'b0000;
         cnt   <= '0;
         acc   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept_mul) begin
                  acc   <= '0;
                  cnt   <= CNT_W'(WIDTH);
                  state <= MUL;
                  busy  <= 1'b1;
               end else if (accept) begin
                  d_out <= sc_res;
                  flags <= {sc_res[WIDTH-1], is_zero(sc_res), sc_c, sc_v};
                  done  <= 1'b1;
               end
            end
            MUL: begin
               acc <= acc_nxt;
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  d_out <= acc_nxt[WIDTH-1:0];
                  flags <= {acc_nxt[WIDTH-1], is_zero(acc_nxt[WIDTH-1:0]), 1'b0,
                            |acc_nxt[2*WIDTH-1:WIDTH]};
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arm_alu_mc.sv
// Self-checking bench for arm_alu_mc: directed cases, randomized ops against an arithmetic model,
// multiply handshake timing, ignored starts, back-to-back issue, abort by reset, MUL_EN=0 variant.
module tb_arm_alu_mc;
   localparam int W = 16;
   localparam longint M = longint'(1) << W;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          start1 = 1'b0;
   logic [2:0]    op = 3'b000;
   logic          cin = 1'b0;
   logic [W-1:0]  rd = '0;
   logic [W-1:0]  rs = '0;
   logic          busy, done, wen, busy1, done1, wen1;
   logic [W-1:0]  d_out, d_out1;
   logic [3:0]    flags, flags1;
   int            n_tests = 0;
   int            n_fail = 0;

   arm_alu_mc #(.WIDTH(W), .MUL_EN(1)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .cin(cin),
      .rd_data(rd), .rs_data(rs), .busy(busy), .done(done), .wen(wen),
      .d_out(d_out), .flags(flags));

   arm_alu_mc #(.WIDTH(W), .MUL_EN(0)) dut_nomul (
      .clk(clk), .reset(reset), .start(start1), .op(op), .cin(cin),
      .rd_data(rd), .rs_data(rs), .busy(busy1), .done(done1), .wen(wen1),
      .d_out(d_out1), .flags(flags1));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: {N,Z,C,V,result} from plain integer arithmetic on the operation definitions.
   function automatic logic [W+3:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic c);
      longint ua, ub, sa, sb, full, sres;
      logic cf, vf;
      logic [W-1:0] res;
      ua = longint'(a);
      ub = longint'(b);
      sa = a[W-1] ? ua - M : ua;
      sb = b[W-1] ? ub - M : ub;
      sres = 0;
      cf = 1'b0;
      vf = 1'b0;
      case (o)
         3'd0: begin full = ua + ub; cf = full >= M; sres = sa + sb; end
         3'd1: begin full = ua - ub + M; cf = ua >= ub; sres = sa - sb; end
         3'd2: begin full = ub + longint'(c); cf = full >= M; sres = sb + longint'(c); end
         3'd3: begin full = ub / 2; cf = b[0]; end
         3'd4: begin full = ub + M - 1; cf = full >= M; sres = sb - 1; end
         3'd5: begin full = ua * ub; vf = (full / M) != 0; end
         3'd6: begin full = ub * 2; cf = b[W-1]; end
         default: full = ua;
      endcase
      if (o <= 3'd2 || o == 3'd4) vf = (sres > (M / 2 - 1)) || (sres < -(M / 2));
      res = W'(full % M);
      return {res[W-1], res == 0, cf, vf, res};
   endfunction

   task automatic run_single(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c, input string name);
      logic [W+3:0] exp;
      exp = model(o, a, b, c);
      op = o; rd = a; rs = b; cin = c; start = 1'b1;
      tick();
      start = 1'b0;
      n_tests++;
      if (d_out !== exp[W-1:0] || flags !== exp[W+3:W]) begin
         n_fail++;
         $display("FAIL %s op=%0d rd=%h rs=%h cin=%b: d_out=%h flags=%b, required %h %b",
                  name, o, a, b, c, d_out, flags, exp[W-1:0], exp[W+3:W]);
      end
      n_tests++;
      if (done !== 1'b1 || wen !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_handshake: done=%b wen=%b busy=%b, required 1 1 0", name, done, wen, busy);
      end
      tick();
      n_tests++;
      if (done !== 1'b0 || wen !== 1'b0 || d_out !== exp[W-1:0] || flags !== exp[W+3:W]) begin
         n_fail++;
         $display("FAIL %s_hold: done=%b wen=%b d_out=%h flags=%b, required 0 0 %h %b",
                  name, done, wen, d_out, flags, exp[W-1:0], exp[W+3:W]);
      end
   endtask

   // Leaves the bench in the done cycle so a caller can issue back-to-back.
   task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject,
                          input string name);
      logic [W+3:0] exp;
      int cyc, bc;
      exp = model(3'd5, a, b, 1'b0);
      op = 3'd5; rd = a; rs = b; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      bc = 0;
      while (!done && cyc < 3 * W) begin
         if (busy) bc++;
         if (inject && cyc == 3) begin
            start = 1'b1; op = 3'd0; rd = 16'h0001; rs = 16'h0001;
         end
         if (cyc == 4) start = 1'b0;
         if (inject && cyc == 6) begin rd = $urandom; rs = $urandom; end
         tick();
         cyc++;
      end
      n_tests++;
      if (done !== 1'b1 || wen !== 1'b1 || busy !== 1'b0 || cyc != W || bc != W) begin
         n_fail++;
         $display("FAIL %s_timing: done=%b wen=%b busy=%b after %0d cycles, busy for %0d, required done after %0d, busy %0d",
                  name, done, wen, busy, cyc, bc, W, W);
      end
      n_tests++;
      if (d_out !== exp[W-1:0] || flags !== exp[W+3:W]) begin
         n_fail++;
         $display("FAIL %s rd=%h rs=%h: d_out=%h flags=%b, required %h %b",
                  name, a, b, d_out, flags, exp[W-1:0], exp[W+3:W]);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || wen !== 1'b0 || d_out !== '0 || flags !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b wen=%b d_out=%h flags=%b, required all zero",
                  busy, done, wen, d_out, flags);
      end
   endtask

   task automatic test_directed();
      run_single(3'd0, 16'hFFFF, 16'h0001, 1'b0, "add_wrap");
      n_tests++;
      if (flags !== 4'b0110) begin
         n_fail++;
         $display("FAIL add_wrap_flags: flags=%b, required 0110", flags);
      end
      run_single(3'd1, 16'h0005, 16'h0007, 1'b0, "sub_neg");
      run_single(3'd1, 16'h8000, 16'h0001, 1'b0, "sub_ovf");
      run_single(3'd1, 16'h1234, 16'h1234, 1'b0, "sub_eq");
      run_single(3'd3, 16'h0000, 16'h8001, 1'b0, "lsr");
      run_single(3'd6, 16'h0000, 16'h8001, 1'b0, "lsl");
      run_single(3'd2, 16'h0000, 16'h00FF, 1'b1, "mov_cin");
      run_single(3'd2, 16'h0000, 16'h7FFF, 1'b1, "mov_ovf");
      run_single(3'd4, 16'h0000, 16'h0000, 1'b0, "dec_zero");
      run_single(3'd4, 16'h0000, 16'h8000, 1'b0, "dec_ovf");
      run_single(3'd7, 16'hA5A5, 16'h0000, 1'b0, "pass");
      run_mul(16'h0123, 16'h0045, 1'b0, "mul_basic");
      tick();
      run_mul(16'h1000, 16'h0010, 1'b0, "mul_hi");
      tick();
      run_mul(16'hFFFF, 16'hFFFF, 1'b0, "mul_max");
      tick();
   endtask

   task automatic test_back_to_back();
      run_mul(16'h0123, 16'h0045, 1'b1, "mul_ignored_start");
      run_single(3'd0, 16'h0001, 16'h0001, 1'b0, "b2b_add");
      run_single(3'd1, 16'h0003, 16'h0001, 1'b0, "b2b_sub1");
   endtask

   task automatic test_random();
      logic [2:0] o;
      logic [W-1:0] a, b;
      for (int i = 0; i < 60; i++) begin
         o = 3'($urandom_range(0, 7));
         a = W'($urandom);
         b = W'($urandom);
         if ($urandom_range(0, 5) == 0) b = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
         if (o == 3'd5) begin
            run_mul(a, b, 1'b0, "rand_mul");
            tick();
         end else begin
            run_single(o, a, b, 1'($urandom), "rand_op");
         end
      end
   endtask

   task automatic test_mul_reset();
      int seen;
      op = 3'd5; rd = 16'h0123; rs = 16'h0045; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || wen !== 1'b0 || d_out !== '0 || flags !== 4'b0000) begin
         n_fail++;
         $display("FAIL mul_abort_state: busy=%b done=%b wen=%b d_out=%h flags=%b, required all zero",
                  busy, done, wen, d_out, flags);
      end
      seen = 0;
      for (int i = 0; i < 2 * W; i++) begin
         if (done || busy) seen++;
         tick();
      end
      n_tests++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL mul_abort_quiet: done/busy high in %0d cycles, required 0", seen);
      end
   endtask

   task automatic test_mul_disabled();
      op = 3'd5; rd = 16'h1234; rs = 16'h0045; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n_tests++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || d_out1 !== 16'h1234) begin
         n_fail++;
         $display("FAIL nomul_pass: done=%b busy=%b d_out=%h, required 1 0 1234", done1, busy1, d_out1);
      end
      tick();
      n_tests++;
      if (done1 !== 1'b0 || d_out1 !== 16'h1234) begin
         n_fail++;
         $display("FAIL nomul_hold: done=%b d_out=%h, required 0 1234", done1, d_out1);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      tick();
      test_random();
      test_mul_reset();
      test_mul_disabled();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/arm_alu_mc.md
Name: arm_alu_mc

Overview:
- Parametrised, multi-cycle successor to the datapath ALU.
- Adds width generalisation, a registered result and NZCV flag register, a start/busy/done handshake, a one-bit left shift, and an iterative shift-add multiplier.
- Sits between the register file and the writeback mux.
- The control FSM pulses start and stalls on busy until done; d_out feeds register write data.

Parameters:
- WIDTH, 16: operand/result width, >= 4.
- MUL_EN, 1: 1 enables iterative multiply; 0 makes op 101 a single-cycle pass of rd_data.
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only when accepting
- op  in  3  operation select
- cin  in  1  carry-in for mov
- rd_data  in  WIDTH  destination operand
- rs_data  in  WIDTH  source operand
- busy  out  1  multiply in progress
- done  out  1  one-cycle completion pulse
- wen  out  1  register write enable (= done)
- d_out  out  WIDTH  registered result
- flags  out  4  {N,Z,C,V}, registered

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, wen=0, d_out=0, flags=0000, counter=0, accumulator=0.
- Reset mid-multiply aborts it with no done pulse.
- Opcodes (all arithmetic mod 2^WIDTH):
  - 000 add: rd+rs.
  - 001 sub: rd+~rs+1.
  - 010 mov: rs+cin.
  - 011 lsr: rs>>1, zero fill.
  - 100 dec: rs+all-ones.
  - 101 mul: rd*rs, low WIDTH bits.
  - 110 lsl: rs<<1, zero fill.
  - 111 pass: rd.
- FSM states IDLE, MUL.
  - Accepting means state==IDLE; a done cycle counts as IDLE, so back-to-back starts are allowed.
  - start while busy=1 is ignored: no queueing, operands not captured.
- Single-cycle ops: start sampled at edge t0 → d_out, flags, done=1 during the cycle after t0; done drops next edge unless a new op completes.
- mul with MUL_EN=1:
  - At edge t0: capture multiplicand=rd, multiplier=rs; clear the 2*WIDTH accumulator; counter=WIDTH; go to MUL; busy=1.
  - Each MUL edge: if multiplier LSB=1, add the shifted multiplicand to the accumulator; shift multiplicand left, multiplier right; decrement counter.
  - The edge where counter goes 1→0 writes d_out=acc low WIDTH, sets done=1, busy=0, state=IDLE.
  - done is therefore high during the cycle after edge t0+WIDTH; busy is high for exactly WIDTH cycles.
  - Operand inputs changing during MUL do not affect the result.
- Flags are written only on completion; they hold otherwise.
  - N = result MSB; Z = result==0.
  - add/sub/mov/dec: C = carry out of the WIDTH-bit adder; sub is no-borrow style, C=1 when rd>=rs unsigned. V = signed overflow.
  - lsr: C = rs[0]; lsl: C = rs[WIDTH-1]; V=0 for both.
  - mul: C=0; V=1 if the high WIDTH bits of the product are nonzero.
  - pass: C=0, V=0.
- d_out holds its last result between completions.

Test Plan:
- Reset, then add rd=0xFFFF rs=0x0001 → next cycle d_out=0x0000, flags N0 Z1 C1 V0, done=wen=1 for exactly 1 cycle.
- sub rd=0x0005 rs=0x0007 → d_out=0xFFFE, N1 Z0 C0 V0. sub rd=0x8000 rs=0x0001 → 0x7FFF, V1 C1.
- lsr rs=0x8001 → 0x4000, C1. lsl rs=0x8001 → 0x0002, C1. mov rs=0x00FF cin=1 → 0x0100.
- mul rd=0x0123 rs=0x0045 → busy high 16 cycles, done in cycle after edge t0+16, d_out=0x4E6F, V0. mul rd=0x1000 rs=0x0010 → d_out=0x0000, Z1, V1.
- During mul, pulse start with add rd=1 rs=1 → ignored, mul result unchanged. Start add in the done cycle → 0x0002 completes the next cycle (back-to-back).
- Assert reset at cycle 8 of a mul → no done; all outputs 0 next cycle. With MUL_EN=0, op 101 rd=0x1234 → single-cycle d_out=0x1234.
